// File: rtl/usb_uart_rx16_if.sv
// Receiver-side bundle: line and tick inputs, consumer acknowledge, buffered frame and status flags.
interface usb_uart_rx16_if #(parameter int DBITS = 8);
  logic             tick16;
  logic             rxd;
  logic             rdack;
  logic [DBITS-1:0] rbr;
  logic             rdrdy;
  logic             ferr;
  logic             oerr;

  modport master (input tick16, rxd, rdack, output rbr, rdrdy, ferr, oerr);
  modport slave  (output tick16, rxd, rdack, input rbr, rdrdy, ferr, oerr);
endinterface

// File: rtl/usb_uart_rx16.sv
// 16x-oversampling UART receiver: start-edge detect, mid-bit sampling, buffered word with ready/framing/overrun flags.
module usb_uart_rx16 #(
  parameter int DBITS = 8,
  parameter int SMID  = 7
) (
  input logic              CLK,
  input logic              rstn,
  usb_uart_rx16_if.master  bus
);
  localparam int BW = $clog2(DBITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_r, state_s;
  logic             sync1_r, sync2_r, prev_r;
  logic [3:0]       tick_r, tick_s;
  logic [BW-1:0]    bitcnt_r, bitcnt_s;
  logic [DBITS-1:0] shift_r, shift_s, rbr_r;
  logic             rdrdy_r, ferr_r, oerr_r;
  logic             done_s;

  // two-flop synchroniser plus one cycle of history for falling-edge detection
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= bus.rxd;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // frame state, tick/bit counters and shift register
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      tick_r   <= 4'd0;
      bitcnt_r <= '0;
      shift_r  <= '0;
    end else begin
      state_r  <= state_s;
      tick_r   <= tick_s;
      bitcnt_r <= bitcnt_s;
      shift_r  <= shift_s;
    end
  end

  // next-state logic; done_s marks the stop-bit sample tick
  always_comb begin
    state_s  = state_r;
    tick_s   = tick_r;
    bitcnt_s = bitcnt_r;
    shift_s  = shift_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (prev_r && !sync2_r) begin
          state_s = START;
          tick_s  = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bus.tick16) begin
          if (tick_r == 4'(SMID)) begin
            tick_s = 4'd0;
            // a high line at mid-start is a glitch, not a frame
            if (!sync2_r) begin
              state_s = DATA;
            end else begin
              state_s = IDLE;
            end
          end else begin
            tick_s = tick_r + 4'd1;
          end
        end else begin
          tick_s = tick_r;
        end
      end
      DATA: begin
        if (bus.tick16) begin
          tick_s = tick_r + 4'd1;
          if (tick_r == 4'd15) begin
            shift_s = {sync2_r, shift_r[DBITS-1:1]};
            if (bitcnt_r == BW'(DBITS - 1)) begin
              bitcnt_s = '0;
              state_s  = STOP;
            end else begin
              bitcnt_s = bitcnt_r + BW'(1);
            end
          end else begin
            shift_s = shift_r;
          end
        end else begin
          tick_s = tick_r;
        end
      end
      STOP: begin
        if (bus.tick16) begin
          tick_s = tick_r + 4'd1;
          // leave mid-stop so the next start edge is caught on back-to-back frames
          if (tick_r == 4'd15) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            done_s = 1'b0;
          end
        end else begin
          tick_s = tick_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // receive buffer and status flags; a completing frame takes priority over rdack
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      rbr_r   <= '0;
      rdrdy_r <= 1'b0;
      ferr_r  <= 1'b0;
      oerr_r  <= 1'b0;
    end else if (done_s) begin
      rbr_r   <= shift_r;
      rdrdy_r <= 1'b1;
      ferr_r  <= ~sync2_r;
      oerr_r  <= rdrdy_r & ~bus.rdack;
    end else if (bus.rdack) begin
      rdrdy_r <= 1'b0;
      ferr_r  <= 1'b0;
      oerr_r  <= 1'b0;
    end
  end

  assign bus.rbr   = rbr_r;
  assign bus.rdrdy = rdrdy_r;
  assign bus.ferr  = ferr_r;
  assign bus.oerr  = oerr_r;
endmodule
